led_pattern_stack_gen: RTL and testbench

//  Parametrised LED pattern generator driving a WIDTH-bit LED bar. Four

---
 rtl/led_pattern_stack_gen.sv | 162 ++++++++++++++++
 tb/tb_led_pattern_stack_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_stack_gen.sv
// LED bar pattern generator: stack-fill left/right, single-dot ring and fill-drain,
// stepped by a prescaled run/hold enable, with a completed-frame pulse and counter.
module led_pattern_stack_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   OUT,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned IDX_W   = $clog2(WIDTH);
  localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IDX_W-1:0]   LAST       = IDX_W'(WIDTH - 1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    STACK_L    = 2'd0,
    STACK_R    = 2'd1,
    RING       = 2'd2,
    FILL_DRAIN = 2'd3
  } mode_e;

  mode_e               act_mode, act_mode_nxt;
  logic [IDX_W-1:0]    k, k_nxt, pos, pos_nxt, lim;
  logic [PRESC_W-1:0]  presc, presc_nxt;
  logic [WIDTH-1:0]    out_nxt;
  logic                frame_done_nxt;
  logic [FRAME_W-1:0]  frame_cnt_nxt;
  logic                step_c, wrap_c;

  // Map (mode, k, pos) to the LED image. In fill-drain, k is the phase (0 fill, 1 drain).
  function automatic logic [WIDTH-1:0] pattern(input mode_e m,
                                               input logic [IDX_W-1:0] kk,
                                               input logic [IDX_W-1:0] pp);
    logic [WIDTH-1:0] ones, stack, rev;
    ones  = '1;
    stack = ~(ones >> kk) | (WIDTH'(1) << pp);
    for (int unsigned i = 0; i < WIDTH; i++) rev[i] = stack[WIDTH-1-i];
    pattern = stack;
    case (m)
      STACK_L:    pattern = stack;
      STACK_R:    pattern = rev;
      RING:       pattern = WIDTH'(1) << pp;
      FILL_DRAIN: pattern = (kk == '0) ? (ones >> (LAST - pp))
                                       : (ones >> ({1'b0, pp} + (IDX_W+1)'(1)));
    endcase
    return pattern;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_mode   <= STACK_L;
      k          <= '0;
      pos        <= '0;
      presc      <= '0;
      OUT        <= WIDTH'(1);
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      act_mode   <= act_mode_nxt;
      k          <= k_nxt;
      pos        <= pos_nxt;
      presc      <= presc_nxt;
      OUT        <= out_nxt;
      frame_done <= frame_done_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

  // Next state: a mode change overrides everything, including a coincident wrap.
  always_comb begin
    act_mode_nxt   = act_mode;
    k_nxt          = k;
    pos_nxt        = pos;
    presc_nxt      = presc;
    out_nxt        = OUT;
    frame_done_nxt = 1'b0;
    frame_cnt_nxt  = frame_cnt;
    step_c         = 1'b0;
    wrap_c         = 1'b0;
    lim            = LAST - k;

    if (mode != act_mode) begin
      act_mode_nxt  = mode_e'(mode);
      k_nxt         = '0;
      pos_nxt       = '0;
      presc_nxt     = '0;
      frame_cnt_nxt = '0;
      out_nxt       = pattern(mode_e'(mode), '0, '0);
    end else if (en) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = '0;
        step_c    = 1'b1;
      end else begin
        presc_nxt = presc + PRESC_W'(1);
      end

      if (step_c) begin
        case (act_mode)
          STACK_L, STACK_R: begin
            if (pos > lim) begin
              k_nxt   = '0;
              pos_nxt = '0;
            end else if (pos < lim) begin
              pos_nxt = pos + IDX_W'(1);
            end else if (k < LAST) begin
              k_nxt   = k + IDX_W'(1);
              pos_nxt = '0;
            end else begin
              k_nxt   = '0;
              pos_nxt = '0;
              wrap_c  = 1'b1;
            end
          end
          RING: begin
            if (k != '0) begin
              k_nxt   = '0;
              pos_nxt = '0;
            end else if (pos == LAST) begin
              pos_nxt = '0;
              wrap_c  = 1'b1;
            end else begin
              pos_nxt = pos + IDX_W'(1);
            end
          end
          FILL_DRAIN: begin
            if (k > IDX_W'(1)) begin
              k_nxt   = '0;
              pos_nxt = '0;
            end else if (pos != LAST) begin
              pos_nxt = pos + IDX_W'(1);
            end else if (k == '0) begin
              k_nxt   = IDX_W'(1);
              pos_nxt = '0;
            end else begin
              k_nxt   = '0;
              pos_nxt = '0;
              wrap_c  = 1'b1;
            end
          end
          default: begin
            k_nxt   = '0;
            pos_nxt = '0;
          end
        endcase

        out_nxt = pattern(act_mode, k_nxt, pos_nxt);
        if (wrap_c) begin
          frame_done_nxt = 1'b1;
          frame_cnt_nxt  = frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_stack_gen.sv
// Randomised scoreboard bench for led_pattern_stack_gen: two instances (PRESCALE 1 and 3)
// checked against frame tables built from the pattern rules.
module tb_led_pattern_stack_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] out0, out1, cnt0, cnt1;
  logic       done0, done1;

  always #5 clk = ~clk;

  led_pattern_stack_gen #(.WIDTH(8), .PRESCALE(1), .FRAME_W(8)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .OUT(out0), .frame_done(done0), .frame_cnt(cnt0));

  led_pattern_stack_gen #(.WIDTH(8), .PRESCALE(3), .FRAME_W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .OUT(out1), .frame_done(done1), .frame_cnt(cnt1));

  typedef struct {
    logic [7:0] out;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] seq [4][36];
  int         seq_len [4] = '{36, 36, 8, 16};
  int         ps [2] = '{1, 3};
  int         m_mode [2], m_idx [2], m_presc [2], m_cnt [2];
  logic       m_done [2];

  task automatic chk(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
  endtask

  // Frame tables: one entry per step of each mode's frame.
  initial begin
    int n;
    int v;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p <= 7 - k; p++) begin
        v = ((32'hFF << (8 - k)) & 32'hFF) | (1 << p);
        seq[0][n] = 8'(v);
        for (int b = 0; b < 8; b++) seq[1][n][b] = v[7-b];
        n++;
      end
    end
    for (int i = 0; i < 8; i++)  seq[2][i] = 8'(1 << i);
    for (int i = 0; i < 8; i++)  seq[3][i] = 8'((1 << (i + 1)) - 1);
    for (int i = 8; i < 16; i++) seq[3][i] = 8'(255 >> (i - 7));
  end

  // Reference model: advance on each clock edge and queue the expected outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          m_mode[d] = 0; m_idx[d] = 0; m_presc[d] = 0; m_cnt[d] = 0; m_done[d] = 1'b0;
        end else if (int'(mode) != m_mode[d]) begin
          m_mode[d] = int'(mode); m_idx[d] = 0; m_presc[d] = 0; m_cnt[d] = 0; m_done[d] = 1'b0;
        end else begin
          m_done[d] = 1'b0;
          if (en) begin
            if (m_presc[d] == ps[d] - 1) begin
              m_presc[d] = 0;
              m_idx[d]++;
              if (m_idx[d] == seq_len[m_mode[d]]) begin
                m_idx[d]  = 0;
                m_done[d] = 1'b1;
                m_cnt[d]  = (m_cnt[d] + 1) % 256;
              end
            end else begin
              m_presc[d]++;
            end
          end
        end
        e.out  = seq[m_mode[d]][m_idx[d]];
        e.done = m_done[d];
        e.cnt  = 8'(m_cnt[d]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  end

  // Monitor: compare registered outputs mid-cycle against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0.OUT",        int'(out0),  int'(e.out));
        chk("d0.frame_done", int'(done0), int'(e.done));
        chk("d0.frame_cnt",  int'(cnt0),  int'(e.cnt));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1.OUT",        int'(out1),  int'(e.out));
        chk("d1.frame_done", int'(done1), int'(e.done));
        chk("d1.frame_cnt",  int'(cnt1),  int'(e.cnt));
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    mode  = 2'd0;
    run(2);
    reset = 1'b0;

    en = 1'b1; mode = 2'd0; run(40);
    mode = 2'd1; run(40);
    mode = 2'd2;
    for (int i = 0; i < 24; i++) begin
      en = (i % 4 != 2);
      run(1);
    end
    en = 1'b1; mode = 2'd3; run(36);

    // Mode change while held, then a mode change landing exactly on the wrap step.
    mode = 2'd0; run(10);
    en = 1'b0; mode = 2'd2; run(3);
    en = 1'b1; mode = 2'd0; run(36);
    mode = 2'd2; run(5);

    // Leave fill-drain from its empty state.
    mode = 2'd3; run(16);
    en = 1'b0; mode = 2'd1; run(3);

    // Asynchronous reset between clock edges.
    en = 1'b1; mode = 2'd0; run(20);
    #2 reset = 1'b1;
    #1;
    chk("async.OUT",        int'(out0),  1);
    chk("async.frame_cnt",  int'(cnt0),  0);
    chk("async.frame_done", int'(done0), 0);
    chk("async.d1.OUT",     int'(out1),  1);
    run(1);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) == 0);
      run(1);
    end
    reset = 1'b0;

    // Long ring run so the frame counter wraps past 255.
    en = 1'b1; mode = 2'd2; run(2100);

    run(2);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
